// File: rtl/sram_sp_byte_enable_clear.sv
// Parametrised single-port synchronous SRAM with per-byte write enables,
// selectable read latency / read-during-write result and a hardware clear engine.
module sram_sp_byte_enable_clear #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    Clk_In,
    input  logic                    Reset_In,
    input  logic [DATA_WIDTH-1:0]   Data_In,
    input  logic [ADDR_WIDTH-1:0]   Address_In,
    input  logic [DATA_WIDTH/8-1:0] Byte_Enable_In,
    input  logic                    Write_Enable,
    input  logic                    Read_Enable,
    input  logic                    Clear_Start,
    output logic [DATA_WIDTH-1:0]   Data_Out,
    output logic                    Read_Valid,
    output logic                    Busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    doWrite;
    logic                    doRead;
    logic [DATA_WIDTH-1:0]   oldWord;
    logic [DATA_WIDTH-1:0]   mergedWord;
    logic [DATA_WIDTH-1:0]   readWord;

    logic                    s1Valid_q;
    logic [DATA_WIDTH-1:0]   s1Data_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   dataOut_q;

    // Clear_Start wins over any access presented on the same edge.
    assign accept  = (state_q == IDLE) && !Clear_Start;
    assign doWrite = accept && Write_Enable;
    assign doRead  = accept && Read_Enable;
    assign oldWord = mem[Address_In];

    always_comb begin
        mergedWord = oldWord;
        for (int i = 0; i < BYTES; i++) begin
            if (Byte_Enable_In[i]) begin
                mergedWord[8*i +: 8] = Data_In[8*i +: 8];
            end
        end
    end

    assign readWord = ((RDW_MODE != 0) && doWrite) ? mergedWord : oldWord;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (Clear_Start) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The array has no reset so an aborted clear leaves untouched words intact.
    always_ff @(posedge Clk_In) begin
        if (state_q == CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (doWrite) begin
            mem[Address_In] <= mergedWord;
        end
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            s1Valid_q <= 1'b0;
            s1Data_q  <= '0;
            valid_q   <= 1'b0;
            dataOut_q <= '0;
        end else if (READ_LATENCY == 2) begin
            s1Valid_q <= doRead;
            if (doRead) begin
                s1Data_q <= readWord;
            end
            valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                dataOut_q <= s1Data_q;
            end
        end else begin
            valid_q <= doRead;
            if (doRead) begin
                dataOut_q <= readWord;
            end
        end
    end

    assign Data_Out   = dataOut_q;
    assign Read_Valid = valid_q;
    assign Busy       = (state_q == CLEAR);

endmodule
